// File: rtl/constants_pkg.sv
// Shared constants and types for the data-RAM arbiter.
package constants_pkg;

  localparam int MEMORY_ADDRESS_BITS = 8;
  localparam int MEMORY_DATA_BITS    = 8;
  localparam int ARB_LOCK_TIMEOUT    = 16;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef enum bit {
    M_EXEC   = 1'b0,
    M_LOADER = 1'b1
  } mem_master_t;

  function automatic logic [1:0] master_onehot(input mem_master_t m);
    return (m == M_LOADER) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with an eligibility mask; pointer names the favoured master.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       advance,
  input  logic       adv_from,
  output logic [1:0] gnt
);

  logic       ptr;
  logic [1:0] elig;

  assign elig = req & mask;

  always_comb begin
    gnt = elig;
    if (elig == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  // After serving a master, the other one is favoured next time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ptr <= 1'b0;
    else if (advance) ptr <= ~adv_from;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the data RAM between exec_unit (m0) and the loader/debug port (m1),
// with ownership lock, lock watchdog and a tagged read-return pipeline.
module mem_arbiter
  import constants_pkg::*;
#(
  parameter int ADDR_BITS    = MEMORY_ADDRESS_BITS,
  parameter int DATA_BITS    = MEMORY_DATA_BITS,
  parameter int LOCK_TIMEOUT = ARB_LOCK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  // Handshake: an access is taken at a rising edge where req && gnt; while req is
  // high and gnt is low the master holds we/lock/addr/wdata stable.
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic                 m0_lock,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [DATA_BITS-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [DATA_BITS-1:0] m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic                 m1_lock,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [DATA_BITS-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [DATA_BITS-1:0] m1_rdata,
  output logic                 rd_ram_en,
  output logic [ADDR_BITS-1:0] rd_ram_addr,
  input  logic [DATA_BITS-1:0] rd_ram_data,
  output logic                 wr_ram_en,
  output logic [ADDR_BITS-1:0] wr_ram_addr,
  output logic [DATA_BITS-1:0] wr_ram_data,
  output logic                 arb_state_dbg
);

  localparam int WD_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOCK_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  arb_state_t     state, state_nxt;
  mem_master_t    owner, owner_nxt;
  logic [WD_W-1:0] wdog, wdog_nxt;

  logic [1:0]           req, lock_mask, rr_gnt;
  logic                 advance, adv_from;
  logic                 accept, acc_m;
  logic                 sel_we, sel_lock;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;
  logic                 tag_v, tag_m;

  assign req       = {m1_req, m0_req};
  assign lock_mask = (state == ARB_LOCKED) ? master_onehot(owner) : 2'b11;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .mask     (lock_mask),
    .advance  (advance),
    .adv_from (adv_from),
    .gnt      (rr_gnt)
  );

  assign m0_gnt = rr_gnt[0] & ~reset;
  assign m1_gnt = rr_gnt[1] & ~reset;
  assign accept = |rr_gnt;
  assign acc_m  = rr_gnt[1];

  assign sel_we    = acc_m ? m1_we    : m0_we;
  assign sel_lock  = acc_m ? m1_lock  : m0_lock;
  assign sel_addr  = acc_m ? m1_addr  : m0_addr;
  assign sel_wdata = acc_m ? m1_wdata : m0_wdata;

  assign arb_state_dbg = state;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    wdog_nxt  = wdog;
    advance   = 1'b0;
    adv_from  = acc_m;
    case (state)
      ARB_OPEN: begin
        wdog_nxt = '0;
        if (accept) begin
          advance = 1'b1;
          if (sel_lock) begin
            state_nxt = ARB_LOCKED;
            owner_nxt = acc_m ? M_LOADER : M_EXEC;
          end
        end
      end
      ARB_LOCKED: begin
        // Only the owner is eligible here, so an accept is always an owner access.
        if (accept) begin
          wdog_nxt = '0;
          advance  = 1'b1;
          if (!sel_lock) state_nxt = ARB_OPEN;
        end else if (wdog == WD_LAST) begin
          state_nxt = ARB_OPEN;
          wdog_nxt  = '0;
          advance   = 1'b1;
          adv_from  = (owner == M_LOADER);
        end else if (wdog != WD_MAX) begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      default: state_nxt = ARB_OPEN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_OPEN;
      owner <= M_EXEC;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      wdog  <= wdog_nxt;
    end
  end

  // RAM command is one registered cycle; the read tag trails it by one more
  // stage so rvalid lines up with the RAM's registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ram_en   <= 1'b0;
      rd_ram_addr <= '0;
      wr_ram_en   <= 1'b0;
      wr_ram_addr <= '0;
      wr_ram_data <= '0;
      tag_v       <= 1'b0;
      tag_m       <= 1'b0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
    end else begin
      rd_ram_en <= accept & ~sel_we;
      wr_ram_en <= accept & sel_we;
      if (accept && !sel_we) rd_ram_addr <= sel_addr;
      if (accept && sel_we) begin
        wr_ram_addr <= sel_addr;
        wr_ram_data <= sel_wdata;
      end
      tag_v <= accept & ~sel_we;
      if (accept) tag_m <= acc_m;
      m0_rvalid <= tag_v & ~tag_m;
      m1_rvalid <= tag_v & tag_m;
    end
  end

  assign m0_rdata = m0_rvalid ? rd_ram_data : '0;
  assign m1_rdata = m1_rvalid ? rd_ram_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed sequences, a grant vector table and a randomized run.
module tb_mem_arbiter;
  import constants_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;
  localparam int N_RAND = 2000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          rd_ram_en, wr_ram_en, arb_state_dbg;
  logic [AW-1:0] rd_ram_addr, wr_ram_addr;
  logic [DW-1:0] rd_ram_data, wr_ram_data;

  mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .rd_ram_en(rd_ram_en), .rd_ram_addr(rd_ram_addr), .rd_ram_data(rd_ram_data),
    .wr_ram_en(wr_ram_en), .wr_ram_addr(wr_ram_addr), .wr_ram_data(wr_ram_data),
    .arb_state_dbg(arb_state_dbg)
  );

  // Synchronous RAM: write at the edge, registered read data one cycle after rd_ram_en.
  logic [DW-1:0] ram [256];
  logic          ram_init;

  function automatic logic [7:0] init_val(input int a);
    if (a == 16) return 8'h5A;
    if (a == 32) return 8'hC3;
    return 8'(a) ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (wr_ram_en) begin
      ram[wr_ram_addr] <= wr_ram_data;
    end
    if (rd_ram_en) rd_ram_data <= ram[rd_ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic lock,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain(input int n);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (n) next_cycle();
  endtask

  function automatic logic [63:0] all_outputs();
    return {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, rd_ram_en,
            wr_ram_en, rd_ram_addr, wr_ram_addr, wr_ram_data, arb_state_dbg};
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic       r0, r1, l0, l1;
    logic [1:0] gnt;
  } vec_t;
  vec_t vecs [18];

  // Scoreboard entry: {master, due cycle, data}.
  logic [40:0] exp_q [$];
  logic [7:0]  model_mem [256];

  task automatic check_rvalid(input int n);
    logic [40:0] e;
    check("rvalid_exclusive", {31'd0, m0_rvalid & m1_rvalid}, 32'd0);
    if (m0_rvalid || m1_rvalid) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rvalid_master", {31'd0, m1_rvalid}, {31'd0, e[40]});
        check("rvalid_cycle", n, e[39:8]);
        check("rvalid_data", {24'd0, m1_rvalid ? m1_rdata : m0_rdata}, {24'd0, e[7:0]});
      end
    end else if (exp_q.size() != 0 && int'(exp_q[0][39:8]) <= n) begin
      e = exp_q.pop_front();
      check("rvalid_missing", 32'd0, 32'd1);
    end
  endtask

  initial begin
    logic [7:0] ra [2];
    logic [7:0] rw [2];
    logic       pend [2], rwe [2], rlk [2];
    bit         mdl_locked;
    int         mdl_owner, mdl_ptr, mdl_idle, g;
    logic [1:0] eg;

    reset = 1'b1;
    ram_init = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) next_cycle();
    check("reset_outputs", 32'(all_outputs() != 0), 32'd0);
    reset = 1'b0;
    ram_init = 1'b0;

    // Contention: both read from cycle 0, m0 favoured.
    drive(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    check("cont_gnt0", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    next_cycle(); drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("cont_gnt1", {30'd0, m1_gnt, m0_gnt}, 32'b10);
    check("cont_rd0", {23'd0, rd_ram_en, rd_ram_addr}, {23'd0, 1'b1, 8'h10});
    next_cycle(); drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("cont_rv0", {22'd0, m0_rvalid, m1_rvalid, m0_rdata}, {22'd0, 2'b10, 8'h5A});
    check("cont_rd1", {23'd0, rd_ram_en, rd_ram_addr}, {23'd0, 1'b1, 8'h20});
    next_cycle(); @(negedge clk);
    check("cont_rv1", {22'd0, m0_rvalid, m1_rvalid, m1_rdata}, {22'd0, 2'b01, 8'hC3});
    next_cycle(); @(negedge clk);
    check("cont_rv_end", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);

    // Lock: m1 is shut out until m0's unlocking read is taken.
    next_cycle();
    drive(0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
    @(negedge clk);
    check("lock_first", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    next_cycle(); drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("lock_gap", {30'd0, m1_gnt, m0_gnt}, 32'b00);
    check("lock_state", {31'd0, arb_state_dbg}, 32'd1);
    next_cycle(); drive(0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    @(negedge clk);
    check("lock_unlock", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    next_cycle(); drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("lock_m1_after", {30'd0, m1_gnt, m0_gnt}, 32'b10);
    next_cycle();
    idle_drain(3);

    // Watchdog: m1_gnt rises exactly TO cycles after the owner drops req.
    drive(0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h06, 8'h00);
    @(negedge clk);
    check("wdog_lock", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    next_cycle(); drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k <= TO; k++) begin
      @(negedge clk);
      check($sformatf("wdog_c%0d", k), {31'd0, m1_gnt}, 32'(k == TO));
      if (k < TO) next_cycle();
    end
    next_cycle();
    idle_drain(3);

    // Write-then-read of the same address by m1.
    drive(1, 1'b1, 1'b1, 1'b0, 8'h30, 8'h77);
    @(negedge clk);
    check("wr_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b10);
    next_cycle(); drive(1, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
    @(negedge clk);
    check("wr_cmd", {14'd0, wr_ram_en, rd_ram_en, wr_ram_addr, wr_ram_data},
          {14'd0, 2'b10, 8'h30, 8'h77});
    check("rd_gnt", {31'd0, m1_gnt}, 32'd1);
    next_cycle(); drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("rd_cmd", {21'd0, wr_ram_en, rd_ram_en, m1_rvalid, rd_ram_addr},
          {21'd0, 3'b010, 8'h30});
    next_cycle(); @(negedge clk);
    check("wr_rd_data", {23'd0, m1_rvalid, m1_rdata}, {23'd0, 1'b1, 8'h77});
    next_cycle(); @(negedge clk);
    check("wr_rd_single", {31'd0, m1_rvalid}, 32'd0);
    next_cycle();

    // Throughput: 8 locked reads stream with no bubbles; m1 waits for the watchdog.
    for (int k = 0; k <= 12; k++) begin
      if (k < 8) drive(0, 1'b1, 1'b0, 1'b1, 8'(8'h40 + k), 8'h00);
      else       drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      if (k == 0) drive(1, 1'b1, 1'b0, 1'b0, 8'h07, 8'h00);
      @(negedge clk);
      check($sformatf("tp_m1gnt_%0d", k), {31'd0, m1_gnt}, 32'(k == 12));
      if (k < 8) check($sformatf("tp_m0gnt_%0d", k), {31'd0, m0_gnt}, 32'd1);
      check($sformatf("tp_rden_%0d", k), {31'd0, rd_ram_en}, 32'(k >= 1 && k <= 8));
      check($sformatf("tp_rv_%0d", k), {31'd0, m0_rvalid}, 32'(k >= 2 && k <= 9));
      if (k >= 2 && k <= 9)
        check($sformatf("tp_data_%0d", k), {24'd0, m0_rdata}, {24'd0, init_val(8'h40 + k - 2)});
      next_cycle();
    end
    idle_drain(3);

    // Reset mid-read: outputs clear at once, dropped read never returns.
    drive(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    check("rst_pre_gnt", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    next_cycle();
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    reset = 1'b1;
    drive(1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    #1;
    check("rst_mid_read", 32'(all_outputs() != 0), 32'd0);
    drive(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    repeat (2) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_first_gnt", {28'd0, m1_gnt, m0_gnt, m0_rvalid, m1_rvalid}, 32'b0100);
    next_cycle(); drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("rst_second", {28'd0, m1_gnt, m0_gnt, m0_rvalid, m1_rvalid}, 32'b1000);
    next_cycle(); drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("rst_rv", {22'd0, m0_rvalid, m1_rvalid, m0_rdata}, {22'd0, 2'b10, 8'h5A});
    idle_drain(3);

    // Grant table applied from reset.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b10};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
    pulse_reset();
    for (int k = 0; k < 18; k++) begin
      drive(0, vecs[k].r0, 1'b0, vecs[k].l0, 8'(k), 8'h00);
      drive(1, vecs[k].r1, 1'b0, vecs[k].l1, 8'(k), 8'h00);
      @(negedge clk);
      check($sformatf("vec_%0d", k), {30'd0, m1_gnt, m0_gnt}, {30'd0, vecs[k].gnt});
      next_cycle();
    end
    idle_drain(3);

    // Randomized run against the rule-level model.
    pulse_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
    mdl_locked = 1'b0; mdl_owner = 0; mdl_ptr = 0; mdl_idle = 0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; rwe[m] = 1'b0; rlk[m] = 1'b0; ra[m] = '0; rw[m] = '0;
    end
    for (int n = 0; n < N_RAND + 4; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && n < N_RAND && $urandom_range(0, 99) < 55) begin
          pend[m] = 1'b1;
          rwe[m]  = ($urandom_range(0, 2) == 0);
          rlk[m]  = ($urandom_range(0, 3) == 0);
          ra[m]   = 8'($urandom_range(0, 15));
          rw[m]   = 8'($urandom_range(0, 255));
        end
        drive(m, pend[m], rwe[m], rlk[m], ra[m], rw[m]);
      end
      @(negedge clk);
      g = -1;
      if (!mdl_locked) begin
        if (pend[0] && pend[1]) g = mdl_ptr;
        else if (pend[0])       g = 0;
        else if (pend[1])       g = 1;
      end else if (pend[mdl_owner]) begin
        g = mdl_owner;
      end
      eg = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      check("rand_gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, eg});
      check_rvalid(n);
      if (g >= 0) begin
        mdl_ptr = 1 - g;
        if (mdl_locked) begin
          mdl_idle = 0;
          if (!rlk[g]) mdl_locked = 1'b0;
        end else if (rlk[g]) begin
          mdl_locked = 1'b1;
          mdl_owner  = g;
          mdl_idle   = 0;
        end
        if (rwe[g]) model_mem[ra[g]] = rw[g];
        else        exp_q.push_back({1'(g), 32'(n + 2), model_mem[ra[g]]});
        pend[g] = 1'b0;
      end else if (mdl_locked) begin
        mdl_idle++;
        if (mdl_idle == TO) begin
          mdl_locked = 1'b0;
          mdl_ptr    = 1 - mdl_owner;
          mdl_idle   = 0;
        end
      end
      next_cycle();
    end
    check("rand_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
